// File: rtl/shared_unit_rr_sched.sv
// Round-robin issue scheduler sharing one 2-input combine unit among NUM_REQ requesters,
// with an in-flight credit limit and tag-routed result return.

module shared_unit_rr_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic hit_i,
  output logic resp_valid_o
);
  logic resp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) resp_q <= 1'b0;
    else        resp_q <= hit_i;
  end

  assign resp_valid_o = resp_q;
endmodule

module shared_unit_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int MAX_OUT = 3,
  parameter int TAG_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      unit_in_valid,
  output logic [DATA_W-1:0]         unit_in_a,
  output logic [DATA_W-1:0]         unit_in_b,
  output logic [TAG_W-1:0]          unit_in_tag,
  input  logic                      unit_out_valid,
  input  logic [DATA_W-1:0]         unit_out_data,
  input  logic [TAG_W-1:0]          unit_out_tag,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic [2:0]                outstanding,
  output logic                      err_tag
);
  logic [NUM_REQ-1:0][DATA_W-1:0] a_lane, b_lane;
  logic [TAG_W-1:0]  ptr_q, ptr_d;
  logic [2:0]        out_q, out_d;
  logic              err_q, err_d;
  logic              iv_q;
  logic [DATA_W-1:0] ia_q, ib_q, rd_q;
  logic [TAG_W-1:0]  itag_q;
  logic              grant, accept;
  logic [TAG_W-1:0]  gidx;
  logic [DATA_W-1:0] ga, gb;

  assign a_lane = req_a;
  assign b_lane = req_b;

  // Scan ptr, ptr+1, ... and take the first valid; gated by the credit limit and reset.
  always_comb begin
    grant     = 1'b0;
    gidx      = '0;
    ga        = '0;
    gb        = '0;
    ptr_d     = ptr_q;
    req_ready = '0;
    if (rst_n && (out_q < 3'(MAX_OUT))) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!grant && req_valid[i] && (i == (int'(ptr_q) + k) % NUM_REQ)) begin
            grant        = 1'b1;
            gidx         = TAG_W'(i);
            ga           = a_lane[i];
            gb           = b_lane[i];
            ptr_d        = TAG_W'((i + 1) % NUM_REQ);
            req_ready[i] = 1'b1;
          end
        end
      end
    end
  end

  // A result is only legal with credit outstanding and an in-range tag; anything else is dropped.
  assign accept = unit_out_valid && (int'(unit_out_tag) < NUM_REQ) && (out_q != 3'd0);
  assign err_d  = err_q | (unit_out_valid & ~accept);

  always_comb begin
    out_d = out_q;
    case ({grant, accept})
      2'b10:   out_d = out_q + 3'd1;
      2'b01:   out_d = out_q - 3'd1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      out_q  <= '0;
      err_q  <= 1'b0;
      iv_q   <= 1'b0;
      ia_q   <= '0;
      ib_q   <= '0;
      itag_q <= '0;
      rd_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      out_q <= out_d;
      err_q <= err_d;
      iv_q  <= grant;
      if (grant) begin
        ia_q   <= ga;
        ib_q   <= gb;
        itag_q <= gidx;
      end
      if (accept) rd_q <= unit_out_data;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    shared_unit_rr_lane u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .hit_i        (accept && (int'(unit_out_tag) == i)),
      .resp_valid_o (resp_valid[i])
    );
  end

  assign unit_in_valid = iv_q;
  assign unit_in_a     = ia_q;
  assign unit_in_b     = ib_q;
  assign unit_in_tag   = itag_q;
  assign resp_data     = rd_q;
  assign outstanding   = out_q;
  assign err_tag       = err_q;
endmodule

// File: tb/tb_shared_unit_rr_sched.sv
// Randomized bench: requesters and the shared unit are modelled here; the scheduler's
// expected behaviour is kept as plain counters, a pointer and a queue of in-flight ops.

module tb_shared_unit_rr_sched;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MO = 3;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            unit_in_valid;
  logic [DW-1:0]   unit_in_a, unit_in_b;
  logic [TW-1:0]   unit_in_tag;
  logic            unit_out_valid;
  logic [DW-1:0]   unit_out_data;
  logic [TW-1:0]   unit_out_tag;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_data;
  logic [2:0]      outstanding;
  logic            err_tag;

  always #5 clk = ~clk;

  shared_unit_rr_sched #(.NUM_REQ(N), .DATA_W(DW), .MAX_OUT(MO), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .unit_in_valid(unit_in_valid), .unit_in_a(unit_in_a), .unit_in_b(unit_in_b),
    .unit_in_tag(unit_in_tag),
    .unit_out_valid(unit_out_valid), .unit_out_data(unit_out_data), .unit_out_tag(unit_out_tag),
    .resp_valid(resp_valid), .resp_data(resp_data), .outstanding(outstanding), .err_tag(err_tag)
  );

  typedef struct {int tag; logic [DW-1:0] d; int cyc;} op_t;
  op_t uq[$];

  bit            pend[N];
  logic [DW-1:0] pa[N], pb[N];
  int total = 0, bad = 0, cyc = 0;

  int            m_ptr, m_out, m_itag;
  bit            m_iv, m_err;
  logic [DW-1:0] m_ia, m_ib, m_rd;
  logic [N-1:0]  m_rv;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_out = 0; m_itag = 0; m_iv = 0; m_err = 0;
    m_ia = '0; m_ib = '0; m_rd = '0; m_rv = '0;
  endtask

  task automatic check_regs();
    chk("in_valid",    unit_in_valid, m_iv);
    chk("in_a",        unit_in_a,     m_ia);
    chk("in_b",        unit_in_b,     m_ib);
    chk("in_tag",      unit_in_tag,   m_itag);
    chk("resp_valid",  resp_valid,    m_rv);
    chk("resp_data",   resp_data,     m_rd);
    chk("outstanding", outstanding,   m_out);
    chk("err_tag",     err_tag,       m_err);
  endtask

  // inj: 0 normal unit, 1 out-of-range tag, 2 spurious in-range result
  task automatic step(int req_pct, int ret_pct, int inj);
    int g, pick;
    bit acc;
    @(negedge clk);
    check_regs();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < req_pct) begin
        pend[i] = 1'b1;
        pa[i]   = DW'($urandom);
        pb[i]   = DW'($urandom);
      end
      req_valid[i]       = pend[i];
      req_a[i*DW +: DW]  = pa[i];
      req_b[i*DW +: DW]  = pb[i];
    end
    unit_out_valid = 1'b0;
    unit_out_tag   = '0;
    unit_out_data  = DW'($urandom);
    if (inj == 1) begin
      unit_out_valid = 1'b1;
      unit_out_tag   = TW'($urandom_range(N, (1 << TW) - 1));
    end else if (inj == 2) begin
      unit_out_valid = 1'b1;
      unit_out_tag   = TW'($urandom_range(0, N - 1));
    end else if (uq.size() > 0 && $urandom_range(0, 99) < ret_pct) begin
      pick = $urandom_range(0, uq.size() - 1);
      if (uq[pick].cyc + 2 <= cyc) begin
        unit_out_valid = 1'b1;
        unit_out_tag   = TW'(uq[pick].tag);
        unit_out_data  = uq[pick].d;
        uq.delete(pick);
      end
    end
    #1;
    g = -1;
    if (m_out < MO)
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    chk("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
    acc = unit_out_valid && (unit_out_tag < N) && (m_out > 0);
    if (g >= 0) begin
      m_iv = 1'b1; m_ia = pa[g]; m_ib = pb[g]; m_itag = g;
      m_ptr = (g + 1) % N;
      pend[g] = 1'b0;
      uq.push_back('{g, pa[g] + pb[g], cyc});
      m_out++;
    end else m_iv = 1'b0;
    if (acc) begin
      m_rv = N'(1 << unit_out_tag);
      m_rd = unit_out_data;
      m_out--;
    end else m_rv = '0;
    if (unit_out_valid && !acc) m_err = 1'b1;
    cyc++;
  endtask

  // One reset cycle with requesters still presenting; the unit is silent while in reset.
  task automatic do_reset();
    @(negedge clk);
    check_regs();
    rst_n = 1'b0;
    unit_out_valid = 1'b0;
    #1;
    chk("ready_in_rst", req_ready, 0);
    model_reset();
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0;
    unit_out_valid = 1'b0; unit_out_data = '0; unit_out_tag = '0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
    repeat (2) @(posedge clk);
    model_reset();

    repeat (300) step(60, 50, 0);
    repeat (150) step(100, 30, 0);
    repeat (40)  step(100, 100, 0);
    repeat (20)  step(0, 100, 0);
    step(0, 0, 2);
    repeat (4) step(0, 0, 0);
    step(0, 0, 1);
    repeat (4) step(0, 0, 0);

    repeat (6) step(100, 0, 0);
    do_reset();
    repeat (12) step(0, 100, 0);
    repeat (150) step(60, 50, 0);

    do_reset();
    repeat (40)  step(100, 40, 0);
    repeat (200) step(50, 60, 0);
    repeat (20)  step(0, 100, 0);
    step(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
